// File: rtl/ram_req_arbiter_if.sv
// Loader, playback-voice and RAM-controller signals of ram_req_arbiter.
// The arbiter uses the slave view; the surrounding system uses master.
interface ram_req_arbiter_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_RD   = 4
);
    logic                   wr_req;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_full;
    logic                   wr_empty;
    logic [N_RD-1:0]        rd_req;
    logic [N_RD*ADDR_W-1:0] rd_addr;
    logic [N_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]      rd_data;
    logic                   mem_cmd_valid;
    logic                   mem_cmd_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic                   mem_ready;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_rdata_valid;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  mem_ready, mem_rdata, mem_rdata_valid,
        output wr_full, wr_empty, rd_valid, rd_data,
        output mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output mem_ready, mem_rdata, mem_rdata_valid,
        input  wr_full, wr_empty, rd_valid, rd_data,
        input  mem_cmd_valid, mem_cmd_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ram_req_arbiter.sv
// Arbitrates one RAM command port between a write FIFO fed by the sample
// loader and N_RD round-robin playback read requesters, with a starvation
// limit that forces one write after WR_STARVE reads.
module ram_req_arbiter #(
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned N_RD       = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned WR_STARVE  = 4
) (
    input  logic             clk,
    input  logic             reset,
    ram_req_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned IDX_W = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int unsigned CNT_W = (WR_STARVE > 0) ? $clog2(WR_STARVE + 1) : 1;

    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(WR_STARVE);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ISSUE_WR = 2'd1;
    localparam logic [1:0] S_ISSUE_RD = 2'd2;
    localparam logic [1:0] S_WAIT_RD  = 2'd3;

    logic [1:0]        r_state;
    logic              r_cmd_valid;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [N_RD-1:0]   r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [IDX_W-1:0]  r_voice;
    logic [IDX_W-1:0]  r_last;
    logic [CNT_W-1:0]  r_starve;

    logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    logic              w_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_rd_acc;
    logic              w_arb_ok;
    logic              w_rd_found;
    logic [IDX_W-1:0]  w_sel;
    logic [IDX_W-1:0]  w_cand;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_full       = (r_count == FIFO_FULL);
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = (r_state == S_ISSUE_WR) && bus.mem_ready;
    assign w_rd_acc     = (r_state == S_ISSUE_RD) && bus.mem_ready;
    // A full FIFO still takes a push in the cycle its head is popped.
    assign w_push       = bus.wr_req && (!w_full || w_pop);
    assign w_sel_addr   = bus.rd_addr[w_sel*ADDR_W +: ADDR_W];
    // While an rd_valid pulse is out its voice has not yet dropped rd_req,
    // so IDLE waits one cycle rather than re-granting a stale request.
    assign w_arb_ok     = (r_rd_valid == '0);

    // Round-robin search starting at the voice after the last grant.
    always_comb begin
        w_rd_found = 1'b0;
        w_sel      = '0;
        w_cand     = '0;
        for (int unsigned i = 0; i < N_RD; i++) begin
            w_cand = IDX_W'((32'(r_last) + 32'd1 + i) % N_RD);
            if (!w_rd_found && bus.rd_req[w_cand]) begin
                w_rd_found = 1'b1;
                w_sel      = w_cand;
            end
        end
    end

    // Command FSM: arbitration, command hold until accepted, read return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd_valid  <= '0;
            r_rd_data   <= '0;
            r_voice     <= '0;
            r_last      <= IDX_W'(N_RD - 1);
        end else begin
            r_rd_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_ok && w_rd_found && (r_starve < STARVE_MAX)) begin
                        r_state     <= S_ISSUE_RD;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= 1'b0;
                        r_mem_addr  <= w_sel_addr;
                        r_voice     <= w_sel;
                        r_last      <= w_sel;
                    end else if (w_arb_ok && !w_fifo_empty) begin
                        r_state     <= S_ISSUE_WR;
                        r_cmd_valid <= 1'b1;
                        r_cmd_we    <= 1'b1;
                        r_mem_addr  <= r_fifo_addr[r_rptr];
                        r_mem_wdata <= r_fifo_data[r_rptr];
                    end
                end
                S_ISSUE_RD: begin
                    if (bus.mem_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_WAIT_RD;
                    end
                end
                S_ISSUE_WR: begin
                    if (bus.mem_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                S_WAIT_RD: begin
                    if (bus.mem_rdata_valid) begin
                        r_rd_data  <= bus.mem_rdata;
                        r_rd_valid <= N_RD'(1) << r_voice;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Write FIFO storage.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= bus.wr_addr;
            r_fifo_data[r_wptr] <= bus.wr_data;
        end
    end

    // Reads granted while writes wait; saturates to force one write through.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_pop || w_fifo_empty) begin
            r_starve <= '0;
        end else if (w_rd_acc && (r_starve != STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign bus.mem_cmd_valid = r_cmd_valid;
    assign bus.mem_cmd_we    = r_cmd_we;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_data       = r_rd_data;
    assign bus.wr_full       = w_full;
    assign bus.wr_empty      = w_fifo_empty && (r_state != S_ISSUE_WR);
endmodule

// File: tb/tb_ram_req_arbiter.sv
// Directed, table-driven bench for ram_req_arbiter with a 1-cycle-latency
// RAM model that answers each read with the low bits of its address.
module tb_ram_req_arbiter;
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 16;
    localparam int unsigned NR = 4;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef struct {
        int            voice;
        logic [DW-1:0] data;
    } pulse_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            voice;
    } vec_t;

    logic clk;
    logic reset;
    logic ready_en;
    logic hold_ret;
    logic inject_spur;

    cmd_t   cmd_log[$];
    pulse_t rd_log[$];
    int     hold_viol   = 0;
    int     onehot_viol = 0;
    int     n_checks;
    int     n_errors;

    logic          ret_pending = 1'b0;
    logic [DW-1:0] ret_data    = '0;
    logic          stall_prev  = 1'b0;
    cmd_t          prev_cmd;
    cmd_t          mon_cmd;
    pulse_t        mon_pulse;

    ram_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .N_RD(NR)) bus ();

    ram_req_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .N_RD(NR), .FIFO_DEPTH(16), .WR_STARVE(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.mem_ready = ready_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model and observers, all sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            ret_pending         = 1'b0;
            stall_prev          = 1'b0;
            bus.mem_rdata_valid = 1'b0;
            bus.mem_rdata       = '0;
        end else begin
            bus.mem_rdata_valid = 1'b0;
            if (ret_pending && !hold_ret) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata       = ret_data;
                ret_pending         = 1'b0;
            end
            if (inject_spur) begin
                bus.mem_rdata_valid = 1'b1;
                bus.mem_rdata       = 16'hDEAD;
            end
            mon_cmd.we   = bus.mem_cmd_we;
            mon_cmd.addr = bus.mem_addr;
            mon_cmd.data = bus.mem_wdata;
            if (stall_prev && (!bus.mem_cmd_valid || mon_cmd.we !== prev_cmd.we ||
                               mon_cmd.addr !== prev_cmd.addr ||
                               (prev_cmd.we && mon_cmd.data !== prev_cmd.data)))
                hold_viol++;
            stall_prev = bus.mem_cmd_valid && !ready_en;
            prev_cmd   = mon_cmd;
            if (bus.mem_cmd_valid && ready_en) begin
                cmd_log.push_back(mon_cmd);
                if (!mon_cmd.we) begin
                    ret_pending = 1'b1;
                    ret_data    = mon_cmd.addr[DW-1:0];
                end
            end
            if (|bus.rd_valid) begin
                if (!$onehot(bus.rd_valid)) onehot_viol++;
                mon_pulse.voice = -1;
                for (int k = 0; k < NR; k++)
                    if (bus.rd_valid[k]) mon_pulse.voice = k;
                mon_pulse.data = bus.rd_data;
                rd_log.push_back(mon_pulse);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd_addr(input int k, input logic [AW-1:0] a);
        bus.rd_addr[k*AW +: AW] = a;
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        bus.wr_req  = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask

    function automatic int count_writes(input int from);
        int n = 0;
        for (int i = from; i < cmd_log.size(); i++)
            if (cmd_log[i].we) n++;
        return n;
    endfunction

    // Runs until every rd_req bit has been answered, dropping each on its pulse.
    task automatic serve_reads(input int budget, output int pulses);
        pulses = 0;
        while (bus.rd_req != '0 && budget > 0) begin
            tick();
            budget--;
            if (|bus.rd_valid) begin
                pulses++;
                bus.rd_req = bus.rd_req & ~bus.rd_valid;
            end
        end
    endtask

    vec_t wr_vec[3];
    vec_t rr_vec[5];

    initial begin
        int cbase, rbase, got, budget, nw;
        logic exp_we;

        wr_vec[0] = '{addr: 27'h10, data: 16'hA001, voice: 0};
        wr_vec[1] = '{addr: 27'h11, data: 16'hA002, voice: 0};
        wr_vec[2] = '{addr: 27'h12, data: 16'hA003, voice: 0};
        rr_vec[0] = '{addr: 27'h100, data: 16'h0100, voice: 0};
        rr_vec[1] = '{addr: 27'h101, data: 16'h0101, voice: 1};
        rr_vec[2] = '{addr: 27'h102, data: 16'h0102, voice: 2};
        rr_vec[3] = '{addr: 27'h103, data: 16'h0103, voice: 3};
        rr_vec[4] = '{addr: 27'h100, data: 16'h0100, voice: 0};

        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        ready_en    = 1'b1;
        hold_ret    = 1'b0;
        inject_spur = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_req  = '0;
        bus.rd_addr = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_cmd_valid", bus.mem_cmd_valid, 0);
        check("rst_cmd_we", bus.mem_cmd_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_wr_full", bus.wr_full, 0);
        check("rst_wr_empty", bus.wr_empty, 1);
        tick();
        reset = 1'b0;

        // Three writes, ready always high
        cbase = cmd_log.size();
        for (int i = 0; i < 3; i++) push(wr_vec[i].addr, wr_vec[i].data);
        tick();
        bus.wr_req = 1'b0;
        repeat (20) tick();
        check("wr3_count", cmd_log.size() - cbase, 3);
        for (int i = 0; i < 3; i++) begin
            if (cbase + i < cmd_log.size()) begin
                check("wr3_we", cmd_log[cbase+i].we, 1);
                check("wr3_addr", cmd_log[cbase+i].addr, wr_vec[i].addr);
                check("wr3_data", cmd_log[cbase+i].data, wr_vec[i].data);
            end
        end
        check("wr3_empty", bus.wr_empty, 1);

        // Fill to full with the RAM stalled; 17th push dropped
        ready_en = 1'b0;
        cbase = cmd_log.size();
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i == 15) check("full_after_15", bus.wr_full, 0);
            if (i == 16) check("full_after_16", bus.wr_full, 1);
            bus.wr_req  = 1'b1;
            bus.wr_addr = AW'(32'h200 + i);
            bus.wr_data = DW'(32'hB000 + i);
        end
        tick();
        bus.wr_req = 1'b0;
        check("full_after_17", bus.wr_full, 1);
        repeat (3) tick();
        check("full_stalled_cmds", cmd_log.size() - cbase, 0);
        ready_en = 1'b1;
        repeat (60) tick();
        check("full_drain_count", cmd_log.size() - cbase, 16);
        for (int i = 0; i < 16; i++) begin
            if (cbase + i < cmd_log.size()) begin
                check("full_drain_addr", cmd_log[cbase+i].addr, 32'h200 + i);
                check("full_drain_data", cmd_log[cbase+i].data, 32'hB000 + i);
            end
        end
        check("full_drain_empty", bus.wr_empty, 1);

        // Round robin over all four voices
        for (int k = 0; k < NR; k++) set_rd_addr(k, AW'(32'h100 + k));
        cbase = cmd_log.size();
        rbase = rd_log.size();
        bus.rd_req = 4'b1111;
        got = 0;
        budget = 200;
        while (got < 5 && budget > 0) begin
            tick();
            budget--;
            if (|bus.rd_valid) got++;
        end
        bus.rd_req = '0;
        check("rr_pulses_in_time", got, 5);
        repeat (10) tick();
        check("rr_pulse_count", rd_log.size() - rbase, 5);
        for (int i = 0; i < 5; i++) begin
            if (rbase + i < rd_log.size()) begin
                check("rr_voice", rd_log[rbase+i].voice, rr_vec[i].voice);
                check("rr_data", rd_log[rbase+i].data, rr_vec[i].data);
            end
            if (cbase + i < cmd_log.size()) begin
                check("rr_cmd_we", cmd_log[cbase+i].we, 0);
                check("rr_cmd_addr", cmd_log[cbase+i].addr, rr_vec[i].addr);
            end
        end

        // Single read latency and no double service of a lone requester
        cbase = cmd_log.size();
        rbase = rd_log.size();
        tick();
        bus.rd_req = 4'b0010;
        tick();
        tick();
        check("lat_no_early_valid", bus.rd_valid, 0);
        tick();
        check("lat_rd_valid", bus.rd_valid, 4'b0010);
        check("lat_rd_data", bus.rd_data, 16'h0101);
        bus.rd_req = '0;
        tick();
        check("lat_pulse_one_cycle", bus.rd_valid, 0);
        repeat (10) tick();
        check("lat_pulse_count", rd_log.size() - rbase, 1);
        check("lat_cmd_count", cmd_log.size() - cbase, 1);

        // Starvation limit: 4 reads then 1 write
        set_rd_addr(0, 27'h300);
        ready_en = 1'b0;
        cbase = cmd_log.size();
        bus.rd_req = 4'b0001;
        tick();
        for (int i = 0; i < 8; i++) push(AW'(32'h400 + i), DW'(32'hC000 + i));
        tick();
        bus.wr_req = 1'b0;
        ready_en = 1'b1;
        nw = 0;
        budget = 400;
        while (nw < 8 && budget > 0) begin
            tick();
            budget--;
            nw = count_writes(cbase);
        end
        bus.rd_req = '0;
        repeat (20) tick();
        check("starve_writes_drained", nw, 8);
        for (int j = 0; j < 40; j++) begin
            if (cbase + j < cmd_log.size()) begin
                exp_we = ((j % 5) == 4);
                check("starve_pattern_we", cmd_log[cbase+j].we, exp_we);
                if (exp_we) check("starve_wr_addr", cmd_log[cbase+j].addr, 32'h400 + j / 5);
            end
        end
        check("starve_empty", bus.wr_empty, 1);

        // Read return outside WAIT_RD is ignored
        rbase = rd_log.size();
        tick();
        inject_spur = 1'b1;
        tick();
        inject_spur = 1'b0;
        repeat (3) tick();
        check("spur_no_pulse", rd_log.size() - rbase, 0);
        check("spur_rd_data_kept", bus.rd_data, 16'h0300);

        // Reset while waiting for read data
        set_rd_addr(2, 27'h520);
        set_rd_addr(3, 27'h530);
        hold_ret = 1'b1;
        cbase = cmd_log.size();
        rbase = rd_log.size();
        bus.rd_req = 4'b0100;
        budget = 50;
        while (cmd_log.size() == cbase && budget > 0) begin
            tick();
            budget--;
        end
        check("rstmid_read_accepted", cmd_log.size() - cbase, 1);
        tick();
        bus.rd_req = '0;
        reset = 1'b1;
        tick();
        check("rstmid_cmd_valid", bus.mem_cmd_valid, 0);
        check("rstmid_rd_valid", bus.rd_valid, 0);
        check("rstmid_rd_data", bus.rd_data, 0);
        tick();
        reset = 1'b0;
        hold_ret = 1'b0;
        repeat (5) tick();
        check("rstmid_no_pulse", rd_log.size() - rbase, 0);
        cbase = cmd_log.size();
        rbase = rd_log.size();
        bus.rd_req = 4'b1100;
        serve_reads(100, got);
        bus.rd_req = '0;
        repeat (5) tick();
        check("rstmid_pulses", got, 2);
        if (cbase < cmd_log.size()) check("rstmid_first_addr", cmd_log[cbase].addr, 27'h520);
        if (rbase + 1 < rd_log.size()) begin
            check("rstmid_first_voice", rd_log[rbase].voice, 2);
            check("rstmid_second_voice", rd_log[rbase+1].voice, 3);
        end

        // Read command held through a 5-cycle stall
        set_rd_addr(1, 27'h610);
        ready_en = 1'b0;
        cbase = cmd_log.size();
        rbase = rd_log.size();
        bus.rd_req = 4'b0010;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_cmd_valid", bus.mem_cmd_valid, 1);
            check("stall_cmd_we", bus.mem_cmd_we, 0);
            check("stall_mem_addr", bus.mem_addr, 27'h610);
            tick();
        end
        ready_en = 1'b1;
        serve_reads(30, got);
        bus.rd_req = '0;
        repeat (5) tick();
        check("stall_pulses", got, 1);
        check("stall_accept_count", cmd_log.size() - cbase, 1);
        check("stall_rd_data", bus.rd_data, 16'h0610);
        check("cmd_hold_violations", hold_viol, 0);
        check("rd_valid_onehot_violations", onehot_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ram_req_arbiter.md
RAM_REQ_ARBITER -- requirements
Module: ram_req_arbiter

Interface
REQ-001 Parameter ADDR_W, default 27: RAM word-address width.
REQ-002 Parameter DATA_W, default 16: RAM word width.
REQ-003 Parameter N_RD, default 4: number of playback read requesters, one per trigger.
REQ-004 Parameter FIFO_DEPTH, default 16: write-request FIFO entries; power of two.
REQ-005 Parameter WR_STARVE, default 4: consecutive read grants allowed while writes are pending.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 wr_req  in  1  loader pushes {wr_addr, wr_data} into the FIFO when high and wr_full is low.
REQ-009 wr_addr  in  ADDR_W  write word address.
REQ-010 wr_data  in  DATA_W  write word data.
REQ-011 wr_full  out  1  FIFO holds FIFO_DEPTH entries.
REQ-012 wr_empty  out  1  FIFO holds 0 entries and no write is in flight.
REQ-013 rd_req  in  N_RD  per-voice read request; held high until the matching rd_valid bit.
REQ-014 rd_addr  in  N_RD*ADDR_W  per-voice address; voice k occupies bits [k*ADDR_W +: ADDR_W].
REQ-015 rd_valid  out  N_RD  one-hot, one-cycle pulse; rd_data is valid for that voice.
REQ-016 rd_data  out  DATA_W  read data; held until the next rd_valid pulse.
REQ-017 mem_cmd_valid  out  1  command to the RAM controller.
REQ-018 mem_cmd_we  out  1  1 = write, 0 = read.
REQ-019 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  command fields.
REQ-020 mem_ready  in  1  command accepted on a cycle where mem_cmd_valid and mem_ready are both high.
REQ-021 mem_rdata  in  DATA_W; mem_rdata_valid  in  1  read return; one cycle per read.

Function
REQ-022 FSM states: IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD.
REQ-023 Arbitration from IDLE:
- If any rd_req bit is set and starve_cnt < WR_STARVE, go to ISSUE_RD.
- Otherwise, if the FIFO is not empty, go to ISSUE_WR.
- Otherwise, stay in IDLE.
REQ-024 Read selection: round-robin, starting at the voice after the last granted one; last granted = N_RD-1 after reset, so voice 0 is searched first.
REQ-025 On entering ISSUE_RD, latch the selected voice index and its rd_addr.
- Drive mem_cmd_valid=1, mem_cmd_we=0, mem_addr=latched address.
- On acceptance, go to WAIT_RD.
REQ-026 WAIT_RD:
- On mem_rdata_valid, register mem_rdata into rd_data and pulse the latched voice's rd_valid the next cycle.
- Return to IDLE.
- Only one read is outstanding at a time.
REQ-027 ISSUE_WR drives the FIFO head with mem_cmd_we=1.
- On acceptance, pop the FIFO and return to IDLE.
- The FIFO entry stays valid and unchanged until it is accepted.
REQ-028 starve_cnt:
- Increments on each read acceptance while the FIFO is non-empty, saturating at WR_STARVE.
- Clears on write acceptance, or when the FIFO is empty.
- When it reaches WR_STARVE, exactly one write is served next.
REQ-029 Minimum command spacing: one IDLE cycle between commands; a read with 1-cycle mem_ready and 1-cycle return latency takes 4 cycles from request to rd_valid.
REQ-030 mem_cmd_valid, once asserted, stays high with constant fields until accepted.
REQ-031 FIFO boundaries:
- Push on wr_full is ignored; data is dropped, and the loader must check wr_full.
- Simultaneous push and pop while full is allowed; the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
REQ-032 An rd_req deasserted before grant is not serviced; after latch, the read completes and the pulse is still issued.
REQ-033 mem_rdata_valid outside WAIT_RD is ignored.

Reset
REQ-034 Reset state: IDLE; FIFO emptied; starve_cnt=0; last granted = N_RD-1.
REQ-035 Reset output values:
- mem_cmd_valid=0, mem_cmd_we=0, mem_addr=0, mem_wdata=0.
- rd_valid=0, rd_data=0.
- wr_full=0, wr_empty=1.
REQ-036 Reset mid-command abandons the in-flight command with no rd_valid pulse; the RAM controller is reset by the same signal.

Verification
REQ-037 Push 3 writes (addr 0x10-0x12, data 0xA001-0xA003) with mem_ready always 1 -> three mem_cmd_we=1 commands, in order, fields exact; then wr_empty=1.
REQ-038 Push 17 writes with mem_ready=0 -> wr_full=1 after the 16th; the 17th is dropped; releasing mem_ready yields exactly 16 writes.
REQ-039 rd_req=4'b1111 held, addresses 0x100 + k, mem_rdata = address -> grants in order 0,1,2,3,0; each rd_valid pulse is paired with rd_data = 0x100 + k.
REQ-040 rd_req=4'b0001 continuous plus 8 queued writes -> pattern of 4 reads then 1 write, repeating; all writes drain.
REQ-041 Reset asserted in WAIT_RD -> next cycle mem_cmd_valid=0 and rd_valid=0; after release, a fresh rd_req[2] gets a grant ahead of voice 3 (round-robin restarts at voice 0).
REQ-042 mem_ready stalled 5 cycles during ISSUE_RD -> mem_addr and mem_cmd_valid stable throughout; exactly one acceptance.
